sum_serial_adder: RTL and testbench

//  Nibble-serial mantissa adder/subtractor for the FP add path. Processes WIDTH-bit

---
 rtl/sum_pkg.sv | 18 +
 rtl/SUM_cla4bit.sv | 34 +++
 rtl/sum_serial_adder.sv | 135 +++++++++++++
 tb/tb_sum_serial_adder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// Shared types and helpers for the FP add-path serial adder and normaliser FSMs.
package sum_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sum_state_e;

    // Width of a counter that must hold 0..nib-1 (at least one bit).
    function automatic int CNT_W(input int nib);
        int w;
        w = $clog2(nib);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/SUM_cla4bit.sv
// Combinational 4-bit carry-lookahead adder slice with group propagate/generate.
module SUM_cla4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout,
    output logic       o_p,
    output logic       o_g
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Bit generate/propagate and lookahead carries for all four positions.
    always_comb begin
        g    = i_a & i_b;
        p    = i_a ^ i_b;
        c[0] = i_cin;
        c[1] = g[0] | (p[0] & i_cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & i_cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & i_cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & i_cin);
        o_sum  = p ^ c[3:0];
        o_cout = c[4];
        o_p    = &p;
        o_g    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/sum_serial_adder.sv
// Nibble-serial mantissa adder/subtractor: one 4-bit CLA slice reused NIB times,
// carry held in a register between nibbles, result assembled in a shift register.
module sum_serial_adder
    import sum_pkg::*;
#(
    parameter int WIDTH = 28
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_zero
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = CNT_W(NIB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("sum_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    sum_state_e       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;

    logic [3:0]       cla_sum;
    logic             cla_cout;
    logic             cla_p;
    logic             cla_g;
    logic             unused_cla_pg;

    // The chain crosses nibbles through carry_q, so group P/G are not needed.
    assign unused_cla_pg = cla_p ^ cla_g;

    SUM_cla4bit u_cla (
        .i_a    (opa_q[3:0]),
        .i_b    (opb_q[3:0]),
        .i_cin  (carry_q),
        .o_sum  (cla_sum),
        .o_cout (cla_cout),
        .o_p    (cla_p),
        .o_g    (cla_g)
    );

    // Next-state: accept in IDLE, one nibble per cycle in RUN, hold result in DONE.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid && ready_q) begin
                    // Subtract as A + ~B + 1; the +1 enters as the initial carry.
                    opa_d   = i_a;
                    opb_d   = i_b ^ {WIDTH{i_sub}};
                    carry_d = i_sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                opa_d   = {4'b0000, opa_q[WIDTH-1:4]};
                opb_d   = {4'b0000, opb_q[WIDTH-1:4]};
                sum_d   = {cla_sum, sum_q[WIDTH-1:4]};
                carry_d = cla_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cout_d  = cla_cout;
                    zero_d  = (sum_d == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_sum   = sum_q;
    assign o_cout  = cout_q;
    assign o_zero  = zero_q;

endmodule

// File: tb/tb_sum_serial_adder.sv
// Scoreboard bench for sum_serial_adder (WIDTH=28): stimulus pushes expected
// results, a negedge monitor pops and compares on every o_valid handshake.
module tb_sum_serial_adder;

    localparam int WIDTH = 28;
    localparam int NIB   = WIDTH / 4;
    localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}};

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             zero;
        int               acc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_zero;

    exp_t exp_q[$];
    int   errs;
    int   checks;
    int   cyc;
    int   last_acc;
    logic prev_v;

    sum_serial_adder #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_sub   (i_sub),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_zero  (o_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: latency on o_valid rise, data on each completed handshake.
    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_result: got sum %h with empty scoreboard", o_sum);
            end else begin
                if (!prev_v) chk("latency", 32'(cyc - exp_q[0].acc), 32'(NIB));
                if (i_ready) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sum", 32'(o_sum), 32'(e.sum));
                    chk("cout", 32'(o_cout), 32'(e.cout));
                    chk("zero", 32'(o_zero), 32'(e.zero));
                end
            end
        end
        prev_v <= rst_n && o_valid;
    end

    // Issue one op once o_ready is seen; push the expected result if requested.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                         input logic [WIDTH-1:0] esum, input logic ecout, input logic push);
        int   n;
        exp_t e;
        n = 0;
        while (!o_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_ready) begin
            checks++;
            errs++;
            $display("FAIL ready_timeout: got o_ready %b expected 1", o_ready);
        end
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_sub   = sub;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_a     = $urandom & MASK;
        i_b     = $urandom & MASK;
        i_sub   = $urandom_range(0, 1);
        last_acc = cyc;
        if (push) begin
            e.sum  = esum;
            e.cout = ecout;
            e.zero = (esum == '0);
            e.acc  = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        int               prev_acc;
        int               n;

        errs = 0; checks = 0; cyc = 0; last_acc = 0; prev_v = 1'b0;
        rst_n = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_sub = 1'b0; i_ready = 1'b1;
        #23;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_sum",   32'(o_sum),   32'd0);
        chk("rst_cout",  32'(o_cout),  32'd0);
        chk("rst_zero",  32'(o_zero),  32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1-3: directed add/sub vectors
        do_op(28'h0000001, 28'h0000001, 1'b0, 28'h0000002, 1'b0, 1'b1); drain();
        do_op(28'hFFFFFFF, 28'h0000001, 1'b0, 28'h0000000, 1'b1, 1'b1); drain();
        do_op(28'h0000005, 28'h0000003, 1'b1, 28'h0000002, 1'b1, 1'b1); drain();
        do_op(28'h0000003, 28'h0000005, 1'b1, 28'hFFFFFFE, 1'b0, 1'b1); drain();
        do_op(28'h0000007, 28'h0000007, 1'b1, 28'h0000000, 1'b1, 1'b1); drain();

        // 4: stall in DONE, stray i_valid pulses must be ignored
        i_ready = 1'b0;
        do_op(28'h0ABCDEF, 28'h0111111, 1'b0, 28'h0BCDF00, 1'b0, 1'b1);
        n = 0;
        while (!o_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("stall_reach_done", 32'(o_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            i_valid = k[0];
            @(posedge clk); #1;
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_ready", 32'(o_ready), 32'd0);
            chk("stall_sum",   32'(o_sum),   32'h0BCDF00);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        drain();
        @(posedge clk); #1;
        chk("post_stall_valid", 32'(o_valid), 32'd0);

        // 5: reset mid-RUN at cnt=3, then a clean op
        do_op(28'h0FFFFFF, 28'h0000001, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_ready", 32'(o_ready), 32'd1);
        chk("abort_sum",   32'(o_sum),   32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(28'h1234567, 28'h0FEDCBA, 1'b0, 28'h2222221, 1'b0, 1'b1); drain();

        // 6: back-to-back ops against an arithmetic reference
        prev_acc = 0;
        for (int k = 0; k < 8; k++) begin
            ra = $urandom & MASK;
            rb = $urandom & MASK;
            rs = $urandom_range(0, 1);
            if (rs) r = {1'b0, ra} + {1'b0, ~rb} + 29'd1;
            else    r = {1'b0, ra} + {1'b0, rb};
            do_op(ra, rb, rs, r[WIDTH-1:0], r[WIDTH], 1'b1);
            if (k > 0) chk("b2b_period", 32'(last_acc - prev_acc), 32'(NIB + 2));
            prev_acc = last_acc;
        end
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
